multicycle_unit_arbiter: RTL
============================

MULTICYCLE_UNIT_ARBITER -- requirements
Module: multicycle_unit_arbiter

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 8, number of requesters; a power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum busy cycles before forced abort; at least 2.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req  in  ENTRY_NUM  level request per requester; held until granted or withdrawn.
REQ-006 SHALL have port flush  in  1  pipeline flush; aborts any in-flight operation.
REQ-007 SHALL have port unitDone  in  1  shared multi-cycle unit reports completion of the current operation.
REQ-008 SHALL have port grant  out  ENTRY_NUM  one-hot issue grant; one-cycle pulse.
REQ-009 SHALL have port grantPtr  out  log2(ENTRY_NUM)  encoded index of grant; 0 when no grant.
REQ-010 SHALL have port unitStart  out  1  start strobe to the unit; equals OR of grant.
REQ-011 SHALL have port unitKill  out  1  abort strobe to the unit; one-cycle pulse.
REQ-012 SHALL have port busy  out  1  high while an operation is owned (state BUSY).
REQ-013 SHALL have port resultValid  out  1  one-cycle pulse when the owner's result completes.
REQ-014 SHALL have port resultPtr  out  log2(ENTRY_NUM)  owner index; valid with resultValid.
REQ-015 SHALL have port timedOut  out  1  sticky error flag.

Function
REQ-016 SHALL implement two states, IDLE and BUSY, plus registers: owner, rrPtr, busyCount.
REQ-017 SHALL, in IDLE with req!=0 and flush=0, grant combinationally in the same cycle one requester: the first set bit of req found scanning indices rrPtr, rrPtr+1, ... modulo ENTRY_NUM.
REQ-018 SHALL, on a grant, register owner=grantPtr, set rrPtr=(grantPtr+1) mod ENTRY_NUM, clear busyCount, and enter BUSY.
REQ-019 SHALL keep grant, unitStart and grantPtr at 0 in BUSY, and in IDLE when flush=1 or req=0.
REQ-020 SHALL, in BUSY with unitDone=1 and flush=0, drive resultValid=1 and resultPtr=owner in that cycle, then return to IDLE.
REQ-021 SHALL allow the next grant no earlier than the cycle after unitDone, giving a minimum issue interval of unit latency+1.
REQ-022 SHALL, in BUSY with flush=1, drive unitKill=1 and return to IDLE; flush overrides a simultaneous unitDone, so resultValid=0 in that cycle.
REQ-023 SHALL leave rrPtr unchanged on a flush or a timeout.
REQ-024 SHALL increment busyCount each BUSY cycle without unitDone; when busyCount reaches TIMEOUT-1 without done or flush, SHALL pulse unitKill, set timedOut, and return to IDLE.
REQ-025 SHALL, with unitDone and the timeout in the same cycle, treat the operation as done: resultValid=1, no kill.
REQ-026 SHALL keep timedOut set until reset.
REQ-027 SHALL ignore unitDone in IDLE.
REQ-028 SHALL ignore a request withdrawn by the owner during BUSY; the result is still reported to owner.
REQ-029 SHALL size busyCount to hold TIMEOUT-1 without overflow.
REQ-030 SHALL compute the rrPtr+1 wrap as index ENTRY_NUM-1 -> 0.

Reset
REQ-031 SHALL, while rst=1, force state=IDLE, rrPtr=0, owner=0, busyCount=0 and timedOut=0.
REQ-032 SHALL, while rst=1, force all outputs to 0 regardless of req, flush or unitDone.
REQ-033 SHALL discard an in-flight operation on reset without pulsing unitKill.
REQ-034 SHALL allow the first grant in the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover round-robin: ENTRY_NUM=8, req=8'b1000_0101 held, unitDone 3 cycles after each start -> grants to 0, 2, 7, 0; each grant 4 cycles apart.
REQ-036 SHALL cover wrap: rrPtr=7, req=8'b1000_0001 -> grant 7, then 0.
REQ-037 SHALL cover simultaneous flush and unitDone in BUSY -> unitKill=1, resultValid=0, IDLE next cycle, rrPtr unchanged.
REQ-038 SHALL cover timeout: TIMEOUT=4, no unitDone -> unitKill pulse in the 4th BUSY cycle, timedOut=1 sticky, next grant possible the following cycle.
REQ-039 SHALL cover flush in IDLE with req=8'hFF -> no grant; grant to index 0 the cycle after flush drops.
REQ-040 SHALL cover reset mid-BUSY -> all outputs 0 immediately, no unitKill; after release, req=8'h10 -> grant 4 (rrPtr=0).

Source files
------------

// File: rtl/multicycle_unit_arbiter.sv
// Round-robin issue arbiter in front of one shared multi-cycle execution unit.
// Grants one requester at a time, tracks the owner until done, flush or timeout.
module multicycle_unit_arbiter #(
    parameter int ENTRY_NUM = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ENTRY_NUM-1:0]         req,
    input  logic                         flush,
    input  logic                         unitDone,
    output logic [ENTRY_NUM-1:0]         grant,
    output logic [$clog2(ENTRY_NUM)-1:0] grantPtr,
    output logic                         unitStart,
    output logic                         unitKill,
    output logic                         busy,
    output logic                         resultValid,
    output logic [$clog2(ENTRY_NUM)-1:0] resultPtr,
    output logic                         timedOut
);

    localparam int PW = $clog2(ENTRY_NUM);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]   busy_count_reg, busy_count_next;
    logic            timed_out_reg, timed_out_next;

    logic [ENTRY_NUM-1:0] rot_req;
    logic                 rot_found;
    logic [PW-1:0]        rot_offset;
    logic [PW-1:0]        pick_ptr;
    logic                 grant_valid;
    logic                 kill_c;
    logic                 done_c;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr;
    // the index sum wraps naturally because ENTRY_NUM is a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_rot
            logic [PW-1:0] src_idx;
            assign src_idx     = rr_ptr_reg + PW'(gi);
            assign rot_req[gi] = req[src_idx];
        end
    endgenerate

    always_comb begin
        rot_found  = 1'b0;
        rot_offset = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_found  = 1'b1;
                rot_offset = PW'(i);
            end
        end
    end

    assign pick_ptr    = rr_ptr_reg + rot_offset;
    assign grant_valid = !rst && (state_reg == IDLE) && !flush && rot_found;

    generate
        for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (pick_ptr == PW'(gi));
        end
    endgenerate

    assign grantPtr  = grant_valid ? pick_ptr : '0;
    assign unitStart = grant_valid;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        busy_count_next = busy_count_reg;
        timed_out_next  = timed_out_reg;
        kill_c          = 1'b0;
        done_c          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next      = BUSY;
                    owner_next      = pick_ptr;
                    rr_ptr_next     = pick_ptr + PW'(1);
                    busy_count_next = '0;
                end
            end
            BUSY: begin
                // Flush beats done, and done beats a coincident timeout.
                if (flush) begin
                    kill_c     = 1'b1;
                    state_next = IDLE;
                end else if (unitDone) begin
                    done_c     = 1'b1;
                    state_next = IDLE;
                end else if (busy_count_reg == CW'(TIMEOUT - 1)) begin
                    kill_c         = 1'b1;
                    timed_out_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    busy_count_next = busy_count_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            rr_ptr_reg     <= '0;
            busy_count_reg <= '0;
            timed_out_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            rr_ptr_reg     <= rr_ptr_next;
            busy_count_reg <= busy_count_next;
            timed_out_reg  <= timed_out_next;
        end
    end

    // Strobes are gated by rst so a reset mid-operation never emits a kill.
    assign unitKill    = kill_c && !rst;
    assign resultValid = done_c && !rst;
    assign resultPtr   = resultValid ? owner_reg : '0;
    assign busy        = (state_reg == BUSY);
    assign timedOut    = timed_out_reg;

endmodule
